// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register with a two-entry skid buffer.
// in_ready comes from a flop; empty stage drives a programmable NOP.
module pipe_skid_stage #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic main_v;
  logic skid_v;
  logic acc;
  logic fire;

  assign main_v = (state_q == BUSY) || (state_q == FULL);
  assign skid_v = (state_q == FULL);
  assign acc    = in_valid & rdy_q;
  assign fire   = main_v & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (acc && fire) begin
          main_d = in_data;
        end else if (acc) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (fire) begin
          main_d  = NOP_VALUE;
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: begin
        main_d  = NOP_VALUE;
        state_d = EMPTY;
      end
    endcase

    // a beat firing alongside flush has already left downstream
    if (flush) begin
      main_d  = NOP_VALUE;
      state_d = EMPTY;
    end

    if (main_v && !out_ready && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    rdy_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready     = rdy_q;
  assign out_valid    = main_v;
  assign out_data     = main_q;
  assign occupancy    = {skid_v, main_v & ~skid_v};
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue model checked every cycle
// plus directed literal expectations.
module tb_pipe_skid_stage;

  localparam int          DW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0020;
  localparam int          CW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cycles;

  pipe_skid_stage #(
    .DATA_W(DW),
    .NOP_VALUE(NOP),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .occupancy(occupancy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: ordered queue of held beats, ready flag, saturating counter
  logic [31:0] q[$];
  bit          m_rdy = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    bit m_acc;
    bit m_fire;
    m_acc  = in_valid && m_rdy;
    m_fire = (q.size() > 0) && out_ready;
    if (rst) begin
      q.delete();
      m_rdy = 1'b0;
      m_cnt = 0;
    end else begin
      if (q.size() > 0 && !out_ready && m_cnt < (1 << CW) - 1)
        m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (m_fire) void'(q.pop_front());
        if (m_acc) q.push_back(in_data);
      end
      m_rdy = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("m_data", out_data, (q.size() > 0) ? q[0] : NOP);
      chk("m_occ", {30'd0, occupancy}, q.size());
      chk("m_ready", {31'd0, in_ready}, {31'd0, m_rdy});
      chk("m_stall", {30'd0, stall_cycles}, m_cnt);
    end
  end

  task automatic drive(input logic r, input logic f, input logic v,
                       input logic [31:0] d, input logic o);
    rst = r;
    flush = f;
    in_valid = v;
    in_data = d;
    out_ready = o;
    @(negedge clk);
  endtask

  task automatic idle(input logic o);
    drive(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, o);
  endtask

  initial begin
    int exp_st[6];
    exp_st = '{1, 2, 3, 3, 3, 3};

    // reset / NOP
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_en = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h99, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h98, 1'b1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'h20);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_occ", {30'd0, occupancy}, 32'd0);
    idle(1'b0);
    chk("rdy_after_rst", {31'd0, in_ready}, 32'd1);

    // streaming
    drive(1'b0, 1'b0, 1'b1, 32'h11, 1'b1);
    chk("str_11", out_data, 32'h11);
    drive(1'b0, 1'b0, 1'b1, 32'h22, 1'b1);
    chk("str_22", out_data, 32'h22);
    drive(1'b0, 1'b0, 1'b1, 32'h33, 1'b1);
    chk("str_33", out_data, 32'h33);
    chk("str_occ", {30'd0, occupancy}, 32'd1);
    idle(1'b1);
    chk("str_empty", out_data, NOP);

    // skid fill and drain
    drive(1'b0, 1'b0, 1'b1, 32'hA1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'hA2, 1'b0);
    chk("skid_occ", {30'd0, occupancy}, 32'd2);
    chk("skid_rdy", {31'd0, in_ready}, 32'd0);
    chk("skid_head", out_data, 32'hA1);
    drive(1'b0, 1'b0, 1'b1, 32'hCC, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'hCD, 1'b1);
    chk("drain_a2", out_data, 32'hA2);
    chk("drain_rdy", {31'd0, in_ready}, 32'd1);
    idle(1'b1);
    chk("drain_done", {31'd0, out_valid}, 32'd0);

    // flush while FULL, with a beat presented
    drive(1'b0, 1'b0, 1'b1, 32'h51, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h52, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'hBB, 1'b0);
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_data", out_data, NOP);
    chk("fl_occ", {30'd0, occupancy}, 32'd0);
    chk("fl_rdy", {31'd0, in_ready}, 32'd1);
    idle(1'b1);
    idle(1'b1);
    chk("fl_no_bb", {31'd0, out_valid}, 32'd0);

    // flush while BUSY discards an accepted beat
    drive(1'b0, 1'b0, 1'b1, 32'h61, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h62, 1'b1);
    chk("flb_occ", {30'd0, occupancy}, 32'd0);
    idle(1'b1);

    // stall counter saturation
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("st_clr", {30'd0, stall_cycles}, 32'd0);
    idle(1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h71, 1'b1);
    for (int i = 0; i < 6; i++) begin
      idle(1'b0);
      chk($sformatf("st_%0d", i), {30'd0, stall_cycles}, exp_st[i]);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("st_rst", {30'd0, stall_cycles}, 32'd0);

    // mid-operation reset with FULL stage
    idle(1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h81, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h82, 1'b0);
    chk("mr_full", {30'd0, occupancy}, 32'd2);
    drive(1'b1, 1'b0, 1'b1, 32'h83, 1'b1);
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_data", out_data, NOP);
    chk("mr_rdy", {31'd0, in_ready}, 32'd0);
    chk("mr_occ", {30'd0, occupancy}, 32'd0);
    idle(1'b1);
    idle(1'b1);
    chk("mr_gone", {31'd0, out_valid}, 32'd0);

    // mixed traffic against the model
    for (int i = 0; i < 60; i++) begin
      drive(1'b0, (i % 23) == 22, (i % 3) != 0,
            32'h1000 + i, (i % 5) < 2);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("mix_empty", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
